// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus arbiter: FSM states, port IDs and
// default bus geometry.
package bus_pkg;

  localparam int unsigned BUS_ADDR_WIDTH      = 32;
  localparam int unsigned BUS_DATA_WIDTH      = 64;
  localparam int unsigned DEFAULT_WAIT_STATES = 2;
  localparam int unsigned CNT_WIDTH           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_t;

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter that times the wait states of one bus access;
// zero flags the final ACCESS cycle.
module bus_wait_counter
  import bus_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory bus between the instruction
// fetch port and the data load/store port.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = BUS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = BUS_DATA_WIDTH,
  parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_valid,
  output logic [31:0]           if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_valid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  state_t                state, state_next;
  port_t                 last_port, lat_port, grant_port;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:2] lat_addr;
  logic                  lat_we;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  cnt_zero;
  logic                  unused_addr_bits;

  // Byte-lane bits never reach the bus.
  assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

  always_comb begin
    grant_port = PORT_IF;
    if (if_req && dm_req) begin
      grant_port = (last_port == PORT_IF) ? PORT_DM : PORT_IF;
    end else if (dm_req) begin
      grant_port = PORT_DM;
    end
  end

  assign grant_any = (state == IDLE) && (if_req || dm_req);

  bus_wait_counter u_wait_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (grant_any),
    .load_value (CNT_WIDTH'(WAIT_STATES)),
    .dec        (state == ACCESS),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (grant_any) state_next = ACCESS;
      ACCESS:  if (cnt_zero)  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_oe    = 1'b0;
    mem_wdata = '0;
    if_valid  = 1'b0;
    dm_valid  = 1'b0;
    unique case (state)
      ACCESS: begin
        mem_addr = {lat_addr[ADDR_WIDTH-1:3], 3'b000};
        if (lat_we) begin
          mem_wr    = 1'b1;
          mem_oe    = 1'b1;
          mem_wdata = lat_wdata;
        end else begin
          mem_rd = 1'b1;
        end
      end
      RESP: begin
        if_valid = (lat_port == PORT_IF);
        dm_valid = (lat_port == PORT_DM);
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_port  <= PORT_IF;
      last_port <= PORT_IF;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_gnt <= grant_any && (grant_port == PORT_IF);
      dm_gnt <= grant_any && (grant_port == PORT_DM);
      if (grant_any) begin
        lat_port  <= grant_port;
        lat_addr  <= (grant_port == PORT_DM) ? dm_addr[ADDR_WIDTH-1:2] : if_addr[ADDR_WIDTH-1:2];
        lat_we    <= (grant_port == PORT_DM) && dm_we;
        lat_wdata <= dm_wdata;
      end
      // Read data is captured on the edge that ends ACCESS so it is valid in RESP.
      if ((state == ACCESS) && cnt_zero) begin
        if (lat_port == PORT_IF) begin
          if_rdata <= lat_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        end else if (!lat_we) begin
          dm_rdata <= mem_rdata;
        end
      end
      if (state == RESP) begin
        last_port <= lat_port;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (WAIT_STATES=2 and 0).
module tb_mem_bus_arbiter;

  logic        clock;
  logic        reset;

  logic        if_req, if_gnt, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_valid;
  logic [31:0] dm_addr;
  logic [63:0] dm_wdata, dm_rdata;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr, mem_oe, busy;
  logic [63:0] mem_wdata, mem_rdata;

  logic        z_if_req, z_if_gnt, z_if_valid;
  logic [31:0] z_if_addr, z_if_rdata;
  logic        z_dm_req, z_dm_we, z_dm_gnt, z_dm_valid;
  logic [31:0] z_dm_addr;
  logic [63:0] z_dm_wdata, z_dm_rdata;
  logic [31:0] z_mem_addr;
  logic        z_mem_rd, z_mem_wr, z_mem_oe, z_busy;
  logic [63:0] z_mem_wdata, z_mem_rdata;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .WAIT_STATES(2)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_oe(mem_oe), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_gnt(z_if_gnt), .if_valid(z_if_valid), .if_rdata(z_if_rdata),
    .dm_req(z_dm_req), .dm_we(z_dm_we), .dm_addr(z_dm_addr), .dm_wdata(z_dm_wdata),
    .dm_gnt(z_dm_gnt), .dm_valid(z_dm_valid), .dm_rdata(z_dm_rdata),
    .mem_addr(z_mem_addr), .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_wdata(z_mem_wdata),
    .mem_oe(z_mem_oe), .mem_rdata(z_mem_rdata), .busy(z_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    if_req   = 1'b0; if_addr = '0;
    dm_req   = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    z_if_req = 1'b0; z_if_addr = '0;
    z_dm_req = 1'b0; z_dm_we = 1'b0; z_dm_addr = '0; z_dm_wdata = '0;
    z_mem_rdata = '0;
    #1 reset = 1'b0;
    #1;
    check("rst_busy",     64'(busy), 64'd0);
    check("rst_strobes",  64'({mem_rd, mem_wr, mem_oe, if_gnt, dm_gnt, if_valid, dm_valid}), 64'd0);
    check("rst_if_rdata", 64'(if_rdata), 64'd0);
    check("rst_dm_rdata", dm_rdata, 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Fetch of the upper word
    if_req = 1'b1; if_addr = 32'h104; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    check("f_gnt",      64'(if_gnt), 64'd1);
    check("f_addr",     64'(mem_addr), 64'h100);
    check("f_rd_c1",    64'(mem_rd), 64'd1);
    check("f_busy",     64'(busy), 64'd1);
    check("f_valid_c1", 64'(if_valid), 64'd0);
    if_req = 1'b0; if_addr = 32'hFFFF_FFF8;
    step();
    check("f_gnt_c2",   64'(if_gnt), 64'd0);
    check("f_rd_c2",    64'(mem_rd), 64'd1);
    check("f_addr_c2",  64'(mem_addr), 64'h100);
    step();
    check("f_rd_c3",    64'(mem_rd), 64'd1);
    check("f_valid_c3", 64'(if_valid), 64'd0);
    step();
    check("f_valid_c4", 64'(if_valid), 64'd1);
    check("f_rdata",    64'(if_rdata), 64'hAAAABBBB);
    check("f_rd_c4",    64'(mem_rd), 64'd0);
    check("f_dmv_c4",   64'(dm_valid), 64'd0);
    step();
    check("f_valid_c5", 64'(if_valid), 64'd0);
    check("f_busy_c5",  64'(busy), 64'd0);
    check("f_hold",     64'(if_rdata), 64'hAAAABBBB);

    // Load
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4C; mem_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    check("l_gnt",      64'(dm_gnt), 64'd1);
    check("l_addr",     64'(mem_addr), 64'h48);
    check("l_rd",       64'(mem_rd), 64'd1);
    check("l_oe",       64'(mem_oe), 64'd0);
    dm_req = 1'b0;
    step(); step(); step();
    check("l_valid",    64'(dm_valid), 64'd1);
    check("l_rdata",    dm_rdata, 64'h0123_4567_89AB_CDEF);
    check("l_ifv",      64'(if_valid), 64'd0);
    check("l_if_hold",  64'(if_rdata), 64'hAAAABBBB);
    step();

    // Store
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 64'h1122_3344_5566_7788;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("s_gnt",      64'(dm_gnt), 64'd1);
    check("s_wr_c1",    64'(mem_wr), 64'd1);
    check("s_oe_c1",    64'(mem_oe), 64'd1);
    check("s_rd_c1",    64'(mem_rd), 64'd0);
    check("s_wdata_c1", mem_wdata, 64'h1122_3344_5566_7788);
    check("s_addr",     64'(mem_addr), 64'h20);
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
    step();
    check("s_oe_c2",    64'(mem_oe), 64'd1);
    check("s_wdata_c2", mem_wdata, 64'h1122_3344_5566_7788);
    step();
    check("s_wr_c3",    64'(mem_wr), 64'd1);
    check("s_valid_c3", 64'(dm_valid), 64'd0);
    step();
    check("s_valid_c4", 64'(dm_valid), 64'd1);
    check("s_oe_c4",    64'(mem_oe), 64'd0);
    check("s_wr_c4",    64'(mem_wr), 64'd0);
    check("s_wdata_c4", mem_wdata, 64'd0);
    check("s_rdata",    dm_rdata, 64'h0123_4567_89AB_CDEF);
    step();

    // Contention right after reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h8;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10;
    mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("c_dm_gnt",   64'(dm_gnt),   64'(k == 1 || k == 11));
      check("c_if_gnt",   64'(if_gnt),   64'(k == 6 || k == 16));
      check("c_dm_valid", 64'(dm_valid), 64'(k == 4 || k == 14));
      check("c_if_valid", 64'(if_valid), 64'(k == 9 || k == 19));
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("c_if_rdata", 64'(if_rdata), 64'hCCCCDDDD);
    check("c_dm_rdata", dm_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
    step();
    check("c_idle", 64'(busy), 64'd0);

    // Reset in the second ACCESS cycle
    if_req = 1'b1; if_addr = 32'h200;
    step();
    if_req = 1'b0;
    step();
    check("r_rd_before", 64'(mem_rd), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("r_rd",     64'(mem_rd), 64'd0);
    check("r_busy",   64'(busy), 64'd0);
    check("r_addr",   64'(mem_addr), 64'd0);
    check("r_valids", 64'({if_valid, dm_valid}), 64'd0);
    check("r_rdata",  64'(if_rdata), 64'd0);
    step(); step();
    check("r_hold_valids", 64'({if_valid, dm_valid, busy}), 64'd0);
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h204;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h30;
    mem_rdata = 64'h5555_6666_7777_8888;
    step();
    check("r_dm_first", 64'(dm_gnt), 64'd1);
    check("r_if_wait",  64'(if_gnt), 64'd0);
    dm_req = 1'b0;
    step(); step(); step();
    check("r_dm_valid", 64'(dm_valid), 64'd1);
    check("r_dm_rdata", dm_rdata, 64'h5555_6666_7777_8888);
    step(); step();
    check("r_if_gnt",   64'(if_gnt), 64'd1);
    if_req = 1'b0;
    step(); step(); step();
    check("r_if_valid", 64'(if_valid), 64'd1);
    check("r_if_rdata", 64'(if_rdata), 64'h55556666);
    step();

    // Idle stability
    for (int k = 0; k < 20; k++) begin
      step();
      check("idle_quiet", 64'({busy, mem_rd, mem_wr, mem_oe, if_gnt, dm_gnt, if_valid, dm_valid}), 64'd0);
    end

    // WAIT_STATES = 0 load
    z_dm_req = 1'b1; z_dm_we = 1'b0; z_dm_addr = 32'h5C; z_mem_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
    step();
    check("z_gnt",      64'(z_dm_gnt), 64'd1);
    check("z_rd_c1",    64'(z_mem_rd), 64'd1);
    check("z_addr",     64'(z_mem_addr), 64'h58);
    z_dm_req = 1'b0;
    step();
    check("z_valid",    64'(z_dm_valid), 64'd1);
    check("z_rdata",    z_dm_rdata, 64'h0F0F_0F0F_0F0F_0F0F);
    check("z_rd_c2",    64'(z_mem_rd), 64'd0);
    step();
    check("z_idle",     64'({z_busy, z_dm_valid, z_if_valid}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
